// File: rtl/alu_acc_datapath.sv
// Execute-stage datapath of the accumulator CPU: combinational 8-op ALU feeding
// a load-enabled accumulator register, plus a zero flag on operand A for SKZ.
module alu_acc_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_ac,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] acc_out,
    output logic             is_zero
);

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_t;

    opcode_t          op;
    logic [WIDTH-1:0] acc;

    assign op = opcode_t'(opcode);

    // Control-flow and store opcodes leave the accumulator value unchanged,
    // so they all pass operand A through.
    always_comb begin
        alu_result = inA;
        case (op)
            OP_ADD:  alu_result = inA + inB;
            OP_AND:  alu_result = inA & inB;
            OP_XOR:  alu_result = inA ^ inB;
            OP_LDA:  alu_result = inB;
            default: alu_result = inA;
        endcase
    end

    assign is_zero = (inA == '0);

    // ld_ac is a plain level-sampled enable; reset wins over any pending load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (ld_ac) begin
            acc <= alu_result;
        end
    end

    assign acc_out = acc;

endmodule

// File: tb/tb_alu_acc_datapath.sv
// Directed bench for alu_acc_datapath: table of ALU/flag vectors plus hand
// sequences for reset, load chain, hold and wrap-around load.
module tb_alu_acc_datapath;

    logic       clk;
    logic       rst;
    logic       ld_ac;
    logic [2:0] opcode;
    logic [7:0] inA;
    logic [7:0] inB;
    logic [7:0] alu_result;
    logic [7:0] acc_out;
    logic       is_zero;

    int checks = 0;
    int errors = 0;

    alu_acc_datapath #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_ac      (ld_ac),
        .opcode     (opcode),
        .inA        (inA),
        .inB        (inB),
        .alu_result (alu_result),
        .acc_out    (acc_out),
        .is_zero    (is_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_res;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r, input logic z);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_res = r; v.exp_zero = z;
        vecs.push_back(v);
    endtask

    // One accumulator step with inA fed from the expected accumulator value.
    task automatic load_step(input string name, input logic [2:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] exp_acc);
        @(negedge clk);
        opcode = op; inA = a; inB = b; ld_ac = 1'b1;
        @(posedge clk);
        #1;
        check8(name, acc_out, exp_acc);
        @(negedge clk);
        ld_ac = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ld_ac = 1'b0; opcode = 3'b000; inA = 8'h00; inB = 8'h00;

        // Reset with a load pending: acc clears asynchronously and stays clear.
        #2;
        ld_ac = 1'b1; opcode = 3'b101; inB = 8'h55; inA = 8'h00;
        rst = 1'b1;
        #1;
        check8("reset_async", acc_out, 8'h00);
        check1("reset_zero_flag", is_zero, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check8("reset_hold_edges", acc_out, 8'h00);
        @(negedge clk);
        rst = 1'b0; ld_ac = 1'b0;

        // Load/ALU chain.
        load_step("chain_lda", 3'b101, 8'h00, 8'd42, 8'd42);
        load_step("chain_add", 3'b010, 8'd42, 8'd25, 8'd67);
        load_step("chain_and", 3'b011, 8'd67, 8'd15, 8'd3);
        load_step("chain_xor", 3'b100, 8'd3,  8'd7,  8'd4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check8("chain_rst_async", acc_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Reset across an edge discards the load; first edge after release loads.
        @(negedge clk);
        opcode = 3'b101; inB = 8'h99; inA = 8'h00; ld_ac = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        check8("rst_beats_load", acc_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check8("first_load_after_rst", acc_out, 8'h99);
        @(negedge clk);
        ld_ac = 1'b0;

        // Hold: inputs move, accumulator does not.
        load_step("hold_preload", 3'b101, 8'h99, 8'h5A, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            opcode = 3'b010; inA = 8'(i * 16); inB = 8'h11;
            #1;
            check8("hold_alu_track", alu_result, 8'(i * 16 + 8'h11));
            @(posedge clk);
            #1;
            check8("hold_acc", acc_out, 8'h5A);
        end

        // Wrap-around add, then load the wrapped zero.
        @(negedge clk);
        opcode = 3'b010; inA = 8'd200; inB = 8'd100;
        #1;
        check8("wrap_200_100", alu_result, 8'd44);
        load_step("wrap_ff_01_load", 3'b010, 8'hFF, 8'h01, 8'h00);

        // Accumulate: ld_ac held high, ADD of inB every edge with inA tracking.
        @(negedge clk);
        opcode = 3'b010; inB = 8'h10; ld_ac = 1'b1; inA = 8'h00;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check8("accumulate", acc_out, 8'(i * 16));
            @(negedge clk);
            inA = 8'(i * 16);
        end
        ld_ac = 1'b0;

        // Combinational table.
        add_vec(3'b000, 8'hA5, 8'h3C, 8'hA5, 1'b0);
        add_vec(3'b001, 8'hA5, 8'h3C, 8'hA5, 1'b0);
        add_vec(3'b110, 8'hA5, 8'h3C, 8'hA5, 1'b0);
        add_vec(3'b111, 8'hA5, 8'h3C, 8'hA5, 1'b0);
        add_vec(3'b010, 8'd200, 8'd100, 8'd44, 1'b0);
        add_vec(3'b010, 8'hFF, 8'h01, 8'h00, 1'b0);
        add_vec(3'b011, 8'hF0, 8'h3C, 8'h30, 1'b0);
        add_vec(3'b100, 8'hF0, 8'h3C, 8'hCC, 1'b0);
        add_vec(3'b101, 8'hA5, 8'h3C, 8'h3C, 1'b0);
        add_vec(3'b000, 8'h00, 8'h77, 8'h00, 1'b1);
        add_vec(3'b001, 8'h00, 8'h77, 8'h00, 1'b1);
        add_vec(3'b010, 8'h00, 8'h77, 8'h77, 1'b1);
        add_vec(3'b011, 8'h00, 8'h77, 8'h00, 1'b1);
        add_vec(3'b100, 8'h00, 8'h77, 8'h77, 1'b1);
        add_vec(3'b101, 8'h00, 8'h77, 8'h77, 1'b1);
        add_vec(3'b110, 8'h00, 8'h77, 8'h00, 1'b1);
        add_vec(3'b111, 8'h00, 8'h77, 8'h00, 1'b1);
        add_vec(3'b010, 8'h01, 8'h00, 8'h01, 1'b0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op; inA = vecs[i].a; inB = vecs[i].b;
            #1;
            check8($sformatf("vec%0d_result", i), alu_result, vecs[i].exp_res);
            check1($sformatf("vec%0d_zero", i), is_zero, vecs[i].exp_zero);
        end
        @(posedge clk);
        #1;
        check8("table_acc_unchanged", acc_out, 8'h30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
